dc_offset_cal: RTL
==================

// Module: dc_offset_cal
// PURPOSE
// - Digital DC-offset calibration loop that generates the 6-bit sign-magnitude current_dac code for the DC offset stage.
// - Watches a 1-bit comparator decision on the offset-corrected signal and runs a 5-step signed successive approximation to null the offset.
// - After convergence it can optionally keep tracking with +/-1 LSB steps.
// - Sits between the comparator/ADC sign output and the DC offset DAC input.
// PARAMETERS
// - SETTLE_CYCLES  16  clk cycles to wait after every code change before sampling (1..255)
// - AVG_LOG2       3   majority vote over 2**AVG_LOG2 comp_valid samples (0..6)
// - TRACK_DEFAULT  0   value loaded into the internal track-enable at reset
// PORTS
// - clk          in   1  single clock, all state on rising edge
// - reset        in   1  asynchronous, active-high; clears all state
// - start        in   1  one-cycle pulse; begins calibration from code 0
// - track_en     in   1  1 = continue +/-1 LSB tracking after DONE
// - comp_valid   in   1  comp_high is valid this cycle
// - comp_high    in   1  1 = corrected output above zero (offset too positive)
// - manual_en    in   1  1 = bypass loop and drive manual_code
// - manual_code  in   6  sign-magnitude override code, [5]=sign, [4:0]=magnitude
// - current_dac  out  6  registered sign-magnitude code; [5]=0 adds +mag, [5]=1 adds -mag
// - busy         out  1  calibration or tracking in progress
// - done         out  1  SAR finished; held until next start, manual_en or reset
// BEHAVIOUR
// - Reset values: current_dac=6'b000000, busy=0, done=0, FSM=IDLE, internal code=0, step=16.
// - Internal code is 6-bit two's complement, clamped to [-31,+31].
// - Output mapping: code>=0 -> {1'b0,code[4:0]}; code<0 -> {1'b1,(-code)[4:0]}. Code 0 always emits 6'b000000, never -0.
// - current_dac is registered and updates on the edge after the internal code or the manual mux changes.
// - FSM states: IDLE, SETTLE, SAMPLE, UPDATE, DONE, TRACK.
// - IDLE: on start, set code=0 and step=16, clear done, set busy=1, go to SETTLE.
// - SETTLE: count SETTLE_CYCLES clk cycles, then go to SAMPLE.
// - SAMPLE: count 2**AVG_LOG2 cycles with comp_valid=1 and tally comp_high. Cycles with comp_valid=0 do not count. Then go to UPDATE.
// - Vote: high if tally > N/2; low if tally < N/2; a tie (tally == N/2) is a tie.
// - UPDATE (SAR phase): high -> code -= step; low or tie -> code += step. Then step >>= 1.
// - UPDATE (SAR phase) exit: if the step just applied was 1, go to DONE; otherwise go to SETTLE.
// - SAR schedule is exactly 5 updates (16, 8, 4, 2, 1), so the reachable range is -31..+31.
// - SAR latency from start: 5*(SETTLE_CYCLES + samples + 1) + 1 cycles to done.
// - DONE: done=1. If track_en=1: busy stays 1 and the FSM goes to SETTLE in tracking mode (done stays 1). Otherwise busy=0 and the FSM waits in DONE.
// - TRACK UPDATE: high -> code-1; low -> code+1; tie -> hold. Clamp at +/-31: no wrap, no change past the limit.
// - Tracking exit: when track_en falls, finish the current cycle, then go to DONE with busy=0.
// - start while busy=1 is ignored. start while in DONE restarts from code 0.
// - manual_en=1: current_dac=manual_code on the next edge; FSM aborts to IDLE; busy=0; done=0.
// - manual_en release: current_dac returns to 0; the loop stays idle until start.
// - A manual_code of 6'b100000 (-0) passes through unchanged.
// - reset mid-operation: immediate asynchronous return to reset values; no partial code retained.
// - Simultaneous start and manual_en: manual_en wins.
// STRUCTURE
// - Package dc_cal_pkg: state enum, MAG_W=5, CODE_MAX=31, STEP_INIT=16, and a function for two's complement to sign-magnitude conversion.
// - Sub-module dc_cal_vote: contains the settle counter, sample counter and tally.
// - dc_cal_vote interface: clear/arm in; vote_done, vote_high, vote_tie out.
// - Top level: holds the FSM, code/step registers and the output mux/register.
// TESTING
// - Default params, comp_high = (dac_value > -13*0.195) driven through a dc_model-style plant:
//   -> code sequence -16, -8, -12, -14, -13, then done; current_dac=6'b101101.
//   -> done asserted exactly 5*(16+8+1)+1 = 126 cycles after start.
// - comp_high forced 0 -> codes +16, +24, +28, +30, +31; current_dac=6'b011111; track_en=1 keeps it at 31 (clamp).
// - comp_high forced 1, track_en=1: SAR ends at -31; tracking holds at 6'b111111 for 10 updates.
// - Alternating 4 high / 4 low samples during tracking -> tie -> code unchanged.
// - Mid-SAR: manual_en=1 with manual_code=6'b000101 -> current_dac=6'b000101 next edge, busy=0, done=0.
// - Mid-SAR: reset pulse -> all outputs 0; later start re-runs SAR from 0.
// - comp_valid held low for 100 cycles during SAMPLE -> no update occurs; FSM remains in SAMPLE.
// - start pulses while busy have no effect on the code sequence.

Source files
------------

// File: rtl/dc_cal_pkg.sv
// Shared types and constants for the DC-offset calibration loop.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: loop state enum, code/step constants, and the conversion from the
// internal two's complement code to the DAC's sign-magnitude format.
package dc_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        UPDATE,
        DONE,
        TRACK
    } state_t;

    localparam int MAG_W     = 5;
    localparam int CODE_MAX  = 31;
    localparam int STEP_INIT = 16;

    // Zero always maps to +0. The internal code is clamped to +/-31, so the
    // negated magnitude always fits in MAG_W bits.
    function automatic logic [MAG_W:0] to_sign_mag(input logic signed [MAG_W:0] code);
        logic [MAG_W:0] neg;
        neg = -code;
        if (code[MAG_W]) begin
            return {1'b1, neg[MAG_W-1:0]};
        end
        return {1'b0, code[MAG_W-1:0]};
    endfunction

endpackage

// File: rtl/dc_cal_vote.sv
// Settle timer plus majority vote over 2**AVG_LOG2 valid comparator samples.
// Latency: SETTLE_CYCLES cycles of settling, then one cycle per valid sample.
// Backpressure: none; cycles with comp_valid=0 simply do not count.
// Ports: clk, reset (async, high); clear aborts everything; arm starts a fresh
// settle+sample round; settle_end / vote_done are high in the final cycle of
// each phase; vote_high / vote_tie hold the result until the next arm or clear.
module dc_cal_vote #(
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic arm,
    input  logic comp_valid,
    input  logic comp_high,
    output logic settle_end,
    output logic vote_done,
    output logic vote_high,
    output logic vote_tie
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;   // tally must hold the value N

    logic [7:0]    settle_cnt;
    logic [CW-1:0] samp_cnt;
    logic [CW-1:0] tally;
    logic          settling;
    logic          sampling;

    // Final-cycle flags are combinational so the controller changes state on
    // the same edge that completes the phase, with no idle cycle in between.
    assign settle_end = settling && (settle_cnt == 8'(SETTLE_CYCLES - 1));
    assign vote_done  = sampling && comp_valid && (samp_cnt == CW'(N - 1));

    // Compare 2*tally against N so that a tie only exists when N is even.
    assign vote_high = ({tally, 1'b0} > (CW+1)'(N));
    assign vote_tie  = ({tally, 1'b0} == (CW+1)'(N));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            tally      <= '0;
            settling   <= 1'b0;
            sampling   <= 1'b0;
        end else if (clear) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            tally      <= '0;
            settling   <= 1'b0;
            sampling   <= 1'b0;
        end else if (arm) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            tally      <= '0;
            settling   <= 1'b1;
            sampling   <= 1'b0;
        end else if (settling) begin
            if (settle_end) begin
                settling <= 1'b0;
                sampling <= 1'b1;
            end else begin
                settle_cnt <= settle_cnt + 8'd1;
            end
        end else if (sampling && comp_valid) begin
            samp_cnt <= samp_cnt + CW'(1);
            tally    <= tally + CW'(comp_high);
            if (vote_done) begin
                sampling <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dc_offset_cal.sv
// DC-offset calibration: 5-step signed SAR on comparator votes, then optional +/-1 tracking.
// Latency: done 5*(SETTLE_CYCLES + samples + 1) + 1 cycles after start; current_dac lags code by one edge.
// Backpressure: none; comparator gaps (comp_valid=0) stretch the sample phase.
// Ports: clk, reset (async, high), start pulse, track_en, comp_valid/comp_high from
// the comparator, manual_en/manual_code override; current_dac sign-magnitude code, busy, done.
module dc_offset_cal
    import dc_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 3,
    parameter bit TRACK_DEFAULT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       track_en,
    input  logic       comp_valid,
    input  logic       comp_high,
    input  logic       manual_en,
    input  logic [5:0] manual_code,
    output logic [5:0] current_dac,
    output logic       busy,
    output logic       done
);

    localparam logic signed [5:0] CODE_HI = 6'(CODE_MAX);
    localparam logic signed [5:0] CODE_LO = 6'(-CODE_MAX);

    state_t            state;
    logic signed [5:0] code;
    logic [4:0]        step;
    logic              tracking;   // current round ends in TRACK rather than UPDATE
    logic              track_q;
    logic              clear;
    logic              arm;
    logic              settle_end;
    logic              vote_done;
    logic              vote_high;
    logic              vote_tie;

    dc_cal_vote #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .AVG_LOG2      (AVG_LOG2)
    ) u_vote (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .arm        (arm),
        .comp_valid (comp_valid),
        .comp_high  (comp_high),
        .settle_end (settle_end),
        .vote_done  (vote_done),
        .vote_high  (vote_high),
        .vote_tie   (vote_tie)
    );

    // Arm the voter on exactly the edges where the FSM below enters SETTLE.
    always_comb begin
        clear = manual_en;
        arm   = 1'b0;
        if (!manual_en) begin
            case (state)
                IDLE:    arm = start;
                UPDATE:  arm = (step != 5'd1);
                DONE:    arm = (start && !busy) || track_q;
                TRACK:   arm = track_q;
                default: arm = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            code        <= '0;
            step        <= 5'(STEP_INIT);
            tracking    <= 1'b0;
            track_q     <= TRACK_DEFAULT;
            busy        <= 1'b0;
            done        <= 1'b0;
            current_dac <= '0;
        end else begin
            track_q     <= track_en;
            current_dac <= manual_en ? manual_code : to_sign_mag(code);
            if (manual_en) begin
                state    <= IDLE;
                code     <= '0;
                step     <= 5'(STEP_INIT);
                tracking <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            code     <= '0;
                            step     <= 5'(STEP_INIT);
                            tracking <= 1'b0;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            state    <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (settle_end) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        if (vote_done) state <= tracking ? TRACK : UPDATE;
                    end
                    UPDATE: begin
                        // A tie resolves upward during the SAR phase.
                        if (vote_high) code <= code - $signed({1'b0, step});
                        else           code <= code + $signed({1'b0, step});
                        step  <= step >> 1;
                        state <= (step == 5'd1) ? DONE : SETTLE;
                    end
                    DONE: begin
                        done <= 1'b1;
                        // The first DONE cycle still has busy=1, so a start
                        // landing there is treated as arriving while busy.
                        if (start && !busy) begin
                            code     <= '0;
                            step     <= 5'(STEP_INIT);
                            tracking <= 1'b0;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            state    <= SETTLE;
                        end else if (track_q) begin
                            busy     <= 1'b1;
                            tracking <= 1'b1;
                            state    <= SETTLE;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    TRACK: begin
                        if (vote_high && code != CODE_LO) begin
                            code <= code - 6'sd1;
                        end else if (!vote_high && !vote_tie && code != CODE_HI) begin
                            code <= code + 6'sd1;
                        end
                        state <= track_q ? SETTLE : DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
